// File: rtl/simd_inst_fetch.sv
// Two-stage instruction fetch between the warp issuer and the SIMD ALU: the
// store is read in S0, the word and its payload are offered to the ALU from S1.
module simd_inst_fetch #(
    parameter  int N_INST    = 16,
    parameter  int WBW       = 16,
    parameter  int VDIM      = 6,
    parameter  int IBW       = 32,
    parameter  int MAX_WARP  = 16,
    parameter  int N_PENDING = 4,
    localparam int INST_BW   = $clog2(N_INST + 1),
    localparam int WID_BW    = $clog2(MAX_WARP),
    localparam int OFS_BW    = WBW * VDIM
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               inst_rdy,
    output logic               inst_ack,
    input  logic [INST_BW-1:0] i_pc,
    input  logic [WID_BW-1:0]  i_warpid,
    input  logic [OFS_BW-1:0]  i_bofs,
    input  logic [OFS_BW-1:0]  i_aofs,
    input  logic               cfg_rdy,
    output logic               cfg_ack,
    input  logic [INST_BW-1:0] i_cfg_addr,
    input  logic [IBW-1:0]     i_cfg_data,
    output logic               alu_rdy,
    input  logic               alu_ack,
    output logic [IBW-1:0]     o_inst,
    output logic [INST_BW-1:0] o_pc,
    output logic [WID_BW-1:0]  o_warpid,
    output logic [OFS_BW-1:0]  o_bofs,
    output logic [OFS_BW-1:0]  o_aofs,
    input  logic               wb_dval,
    output logic               inst_commit_dval
);

    localparam int                 AW       = (N_INST > 1) ? $clog2(N_INST) : 1;
    localparam int                 CW       = $clog2(2 * N_PENDING + 1);
    localparam logic [INST_BW-1:0] PC_LIMIT = INST_BW'(N_INST);
    localparam logic [IBW-1:0]     NOP_WORD = {1'b1, {(IBW - 1){1'b0}}};

    logic [IBW-1:0]     mem_q [N_INST];
    logic [IBW-1:0]     rd_q;

    logic               s0_valid_q, s0_valid_d;
    logic               s0_oor_q,   s0_oor_d;
    logic [INST_BW-1:0] s0_pc_q,    s0_pc_d;
    logic [WID_BW-1:0]  s0_wid_q,   s0_wid_d;
    logic [OFS_BW-1:0]  s0_bofs_q,  s0_bofs_d;
    logic [OFS_BW-1:0]  s0_aofs_q,  s0_aofs_d;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_nop_q,   s1_nop_d;
    logic [IBW-1:0]     s1_inst_q,  s1_inst_d;
    logic [INST_BW-1:0] s1_pc_q,    s1_pc_d;
    logic [WID_BW-1:0]  s1_wid_q,   s1_wid_d;
    logic [OFS_BW-1:0]  s1_bofs_q,  s1_bofs_d;
    logic [OFS_BW-1:0]  s1_aofs_q,  s1_aofs_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               commit_q, commit_d;

    logic               s1_leave_s, s0_adv_s, inst_ack_s, cfg_ack_s;
    logic               pc_in_range_s, cfg_in_range_s, nop_retire_s;
    logic [IBW-1:0]     s0_word_s;

    // Handshake and stage-advance decisions; reset gates the combinational acks.
    always_comb begin
        pc_in_range_s  = (i_pc < PC_LIMIT);
        cfg_in_range_s = (i_cfg_addr < PC_LIMIT);
        s1_leave_s     = s1_valid_q && (s1_nop_q || alu_ack);
        s0_adv_s       = s0_valid_q && (!s1_valid_q || s1_leave_s);
        inst_ack_s     = i_rst && inst_rdy && (!s0_valid_q || s0_adv_s);
        cfg_ack_s      = i_rst && cfg_rdy && !s0_valid_q && !s1_valid_q && !inst_rdy;
        nop_retire_s   = s1_valid_q && s1_nop_q;
        s0_word_s      = s0_oor_q ? NOP_WORD : rd_q;
    end

    // Next-state for both stages and the commit counter.
    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_oor_d   = s0_oor_q;
        s0_pc_d    = s0_pc_q;
        s0_wid_d   = s0_wid_q;
        s0_bofs_d  = s0_bofs_q;
        s0_aofs_d  = s0_aofs_q;
        s1_valid_d = s1_valid_q;
        s1_nop_d   = s1_nop_q;
        s1_inst_d  = s1_inst_q;
        s1_pc_d    = s1_pc_q;
        s1_wid_d   = s1_wid_q;
        s1_bofs_d  = s1_bofs_q;
        s1_aofs_d  = s1_aofs_q;

        if (inst_ack_s) begin
            s0_valid_d = 1'b1;
            s0_oor_d   = !pc_in_range_s;
            s0_pc_d    = i_pc;
            s0_wid_d   = i_warpid;
            s0_bofs_d  = i_bofs;
            s0_aofs_d  = i_aofs;
        end else if (s0_adv_s) begin
            s0_valid_d = 1'b0;
        end else begin
            s0_valid_d = s0_valid_q;
        end

        if (s0_adv_s) begin
            s1_valid_d = 1'b1;
            s1_nop_d   = s0_word_s[IBW-1];
            s1_inst_d  = s0_word_s;
            s1_pc_d    = s0_pc_q;
            s1_wid_d   = s0_wid_q;
            s1_bofs_d  = s0_bofs_q;
            s1_aofs_d  = s0_aofs_q;
        end else if (s1_leave_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // commit_q mirrors (cnt_q != 0), so the decrement can never underflow
        cnt_d    = cnt_q + {{(CW - 1){1'b0}}, nop_retire_s}
                         + {{(CW - 1){1'b0}}, wb_dval}
                         - {{(CW - 1){1'b0}}, commit_q};
        commit_d = (cnt_d != {CW{1'b0}});
    end

    // Instruction store and its read register; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (cfg_ack_s && cfg_in_range_s) begin
            mem_q[i_cfg_addr[AW-1:0]] <= i_cfg_data;
        end
        if (inst_ack_s && pc_in_range_s) begin
            rd_q <= mem_q[i_pc[AW-1:0]];
        end
    end

    // Pipeline and commit state registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s0_valid_q <= 1'b0;
            s0_oor_q   <= 1'b0;
            s0_pc_q    <= {INST_BW{1'b0}};
            s0_wid_q   <= {WID_BW{1'b0}};
            s0_bofs_q  <= {OFS_BW{1'b0}};
            s0_aofs_q  <= {OFS_BW{1'b0}};
            s1_valid_q <= 1'b0;
            s1_nop_q   <= 1'b0;
            s1_inst_q  <= {IBW{1'b0}};
            s1_pc_q    <= {INST_BW{1'b0}};
            s1_wid_q   <= {WID_BW{1'b0}};
            s1_bofs_q  <= {OFS_BW{1'b0}};
            s1_aofs_q  <= {OFS_BW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            commit_q   <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_oor_q   <= s0_oor_d;
            s0_pc_q    <= s0_pc_d;
            s0_wid_q   <= s0_wid_d;
            s0_bofs_q  <= s0_bofs_d;
            s0_aofs_q  <= s0_aofs_d;
            s1_valid_q <= s1_valid_d;
            s1_nop_q   <= s1_nop_d;
            s1_inst_q  <= s1_inst_d;
            s1_pc_q    <= s1_pc_d;
            s1_wid_q   <= s1_wid_d;
            s1_bofs_q  <= s1_bofs_d;
            s1_aofs_q  <= s1_aofs_d;
            cnt_q      <= cnt_d;
            commit_q   <= commit_d;
        end
    end

    assign inst_ack         = inst_ack_s;
    assign cfg_ack          = cfg_ack_s;
    assign alu_rdy          = s1_valid_q && !s1_nop_q;
    assign o_inst           = s1_inst_q;
    assign o_pc             = s1_pc_q;
    assign o_warpid         = s1_wid_q;
    assign o_bofs           = s1_bofs_q;
    assign o_aofs           = s1_aofs_q;
    assign inst_commit_dval = commit_q;

    simd_inst_fetch_chk #(
        .CW      (CW),
        .MAX_CNT (2 * N_PENDING)
    ) u_chk (
        .clk_i   (i_clk),
        .rst_n_i (i_rst),
        .cnt_i   (cnt_q)
    );

endmodule

// Commit counter bound checker: the driver semaphore keeps at most
// 2*N_PENDING commits outstanding.
module simd_inst_fetch_chk #(
    parameter int CW      = 4,
    parameter int MAX_CNT = 8
) (
    input logic          clk_i,
    input logic          rst_n_i,
    input logic [CW-1:0] cnt_i
);

    cnt_bound_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        int'(cnt_i) <= MAX_CNT);

endmodule

// File: tb/tb_simd_inst_fetch.sv
// Scoreboard bench for simd_inst_fetch: issue tasks push expected ALU
// transfers, a negedge monitor pops and compares them and counts pulses.
module tb_simd_inst_fetch;

    localparam int N_INST = 16;

    logic        i_clk, i_rst;
    logic        inst_rdy, inst_ack;
    logic [4:0]  i_pc;
    logic [3:0]  i_warpid;
    logic [95:0] i_bofs, i_aofs;
    logic        cfg_rdy, cfg_ack;
    logic [4:0]  i_cfg_addr;
    logic [31:0] i_cfg_data;
    logic        alu_rdy, alu_ack;
    logic [31:0] o_inst;
    logic [4:0]  o_pc;
    logic [3:0]  o_warpid;
    logic [95:0] o_bofs, o_aofs;
    logic        wb_dval, inst_commit_dval;

    simd_inst_fetch dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .inst_rdy(inst_rdy), .inst_ack(inst_ack),
        .i_pc(i_pc), .i_warpid(i_warpid), .i_bofs(i_bofs), .i_aofs(i_aofs),
        .cfg_rdy(cfg_rdy), .cfg_ack(cfg_ack),
        .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .alu_rdy(alu_rdy), .alu_ack(alu_ack),
        .o_inst(o_inst), .o_pc(o_pc), .o_warpid(o_warpid),
        .o_bofs(o_bofs), .o_aofs(o_aofs),
        .wb_dval(wb_dval), .inst_commit_dval(inst_commit_dval)
    );

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  pc;
        logic [3:0]  wid;
        logic [95:0] bofs;
        logic [95:0] aofs;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] store_model [N_INST];
    int checks = 0, failures = 0;
    int cyc = 0;
    int acc_cnt = 0, commit_cnt = 0, alu_hi_cnt = 0;
    int commit_run = 0, commit_run_max = 0, alu_run = 0, alu_run_max = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] mk_bofs(input logic [4:0] pc, input logic [3:0] wid);
        return {6{{7'd0, pc, wid}}};
    endfunction

    function automatic logic [95:0] mk_aofs(input logic [4:0] pc, input logic [3:0] wid);
        return {6{{wid, 7'h55, pc}}};
    endfunction

    // Monitor: scoreboard compare on every ALU transfer, pulse/run counters.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                if (inst_ack) acc_cnt++;
                if (inst_commit_dval) begin
                    commit_cnt++;
                    commit_run++;
                    if (commit_run > commit_run_max) commit_run_max = commit_run;
                end else begin
                    commit_run = 0;
                end
                if (alu_rdy) begin
                    alu_hi_cnt++;
                    alu_run++;
                    if (alu_run > alu_run_max) alu_run_max = alu_run;
                end else begin
                    alu_run = 0;
                end
                if (alu_rdy && alu_ack) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected: got pc %0h expected no transfer", o_pc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_inst", o_inst, e.inst);
                        check("sb_pc", o_pc, e.pc);
                        check("sb_warpid", o_warpid, e.wid);
                        check("sb_bofs", o_bofs, e.bofs);
                        check("sb_aofs", o_aofs, e.aofs);
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] pc, input logic [3:0] wid);
        exp_t e;
        int   n;
        e.pc   = pc;
        e.wid  = wid;
        e.bofs = mk_bofs(pc, wid);
        e.aofs = mk_aofs(pc, wid);
        e.inst = (pc < 5'(N_INST)) ? store_model[pc[3:0]] : 32'h8000_0000;
        if (!e.inst[31]) sb.push_back(e);
        inst_rdy = 1'b1;
        i_pc     = pc;
        i_warpid = wid;
        i_bofs   = e.bofs;
        i_aofs   = e.aofs;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (inst_ack) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout: got no inst_ack expected accept of pc %0d", pc);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        inst_rdy = 1'b0;
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
        int n;
        cfg_rdy    = 1'b1;
        i_cfg_addr = addr;
        i_cfg_data = data;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (cfg_ack) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL cfg_timeout: got no cfg_ack expected write of addr %0d", addr);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        cfg_rdy = 1'b0;
        store_model[addr[3:0]] = data;
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            wait_cycles(1);
        end
        check("drain_empty", 96'(sb.size()), 96'd0);
        wait_cycles(2);
    endtask

    initial begin
        int a0, c0, h0, t0;
        logic [4:0] pc_mid;
        i_rst = 1'b0; inst_rdy = 1'b1; cfg_rdy = 1'b1; alu_ack = 1'b1; wb_dval = 1'b0;
        i_pc = 5'd0; i_warpid = 4'd0; i_bofs = 96'd0; i_aofs = 96'd0;
        i_cfg_addr = 5'd0; i_cfg_data = 32'd0;

        // reset state with requests pending
        wait_cycles(3);
        check("rst_inst_ack", inst_ack, 1'b0);
        check("rst_cfg_ack", cfg_ack, 1'b0);
        check("rst_alu_rdy", alu_rdy, 1'b0);
        check("rst_commit", inst_commit_dval, 1'b0);
        check("rst_o_inst", o_inst, 32'd0);
        check("rst_o_pc", o_pc, 5'd0);
        check("rst_o_warpid", o_warpid, 4'd0);
        check("rst_o_bofs", o_bofs, 96'd0);
        check("rst_o_aofs", o_aofs, 96'd0);
        inst_rdy = 1'b0; cfg_rdy = 1'b0;
        wait_cycles(1);
        i_rst = 1'b1;
        wait_cycles(2);

        for (int i = 0; i < N_INST; i++) begin
            logic [31:0] w;
            w = 32'h1000_0000 | (32'(i) << 4) | 32'(i);
            if (i == 3) w = 32'h0000_00A5;
            if (i == 5) w = 32'h8000_0005;
            cfg_write(5'(i), w);
        end

        // single instruction: latency, payload, one commit per wb_dval
        issue(5'd3, 4'd2);
        check("lat_alu_rdy_early", alu_rdy, 1'b0);
        wait_cycles(1);
        check("lat_alu_rdy", alu_rdy, 1'b1);
        check("lat_o_inst", o_inst, 32'h0000_00A5);
        check("lat_o_warpid", o_warpid, 4'd2);
        c0 = commit_cnt;
        wb_dval = 1'b1;
        wait_cycles(1);
        wb_dval = 1'b0;
        wait_cycles(4);
        check("wb_commit_count", 96'(commit_cnt - c0), 96'd1);
        drain();

        // back-to-back stream with alu_ack high
        alu_run_max = 0;
        a0 = acc_cnt;
        t0 = cyc;
        for (int i = 0; i < 8; i++) issue(5'(6 + i), 4'(i));
        check("stream_cycles", 96'(cyc - t0), 96'd8);
        check("stream_accepts", 96'(acc_cnt - a0), 96'd8);
        drain();
        check("stream_alu_run", 96'(alu_run_max), 96'd8);

        // backpressure: 4 queued, alu_ack low for 5 cycles
        alu_ack = 1'b0;
        fork
            begin
                issue(5'd8, 4'd1);
                issue(5'd9, 4'd2);
                issue(5'd10, 4'd3);
                issue(5'd11, 4'd4);
            end
            begin
                a0 = acc_cnt;
                wait_cycles(3);
                pc_mid = o_pc;
                wait_cycles(2);
                check("bp_accepts", 96'(acc_cnt - a0), 96'd2);
                check("bp_o_pc_mid", pc_mid, 5'd8);
                check("bp_o_pc_end", o_pc, 5'd8);
                check("bp_alu_rdy", alu_rdy, 1'b1);
                alu_ack = 1'b1;
            end
        join
        drain();

        // NOP with coincident wb_dval on its retire cycle, no alu_ack needed
        alu_ack = 1'b0;
        commit_run_max = 0;
        c0 = commit_cnt;
        h0 = alu_hi_cnt;
        issue(5'd5, 4'd7);
        wait_cycles(1);
        wb_dval = 1'b1;
        wait_cycles(1);
        wb_dval = 1'b0;
        wait_cycles(5);
        check("nop_commits", 96'(commit_cnt - c0), 96'd2);
        check("nop_commit_run", 96'(commit_run_max), 96'd2);
        check("nop_no_alu", 96'(alu_hi_cnt - h0), 96'd0);

        // out-of-range pc behaves as a NOP
        c0 = commit_cnt;
        h0 = alu_hi_cnt;
        issue(5'd16, 4'd9);
        wait_cycles(6);
        check("oor_commits", 96'(commit_cnt - c0), 96'd1);
        check("oor_no_alu", 96'(alu_hi_cnt - h0), 96'd0);

        // config write blocked while S1 holds an instruction
        issue(5'd7, 4'd5);
        wait_cycles(2);
        cfg_rdy = 1'b1; i_cfg_addr = 5'd7; i_cfg_data = 32'h0BAD_F00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("cfg_blocked", cfg_ack, 1'b0);
        end
        @(posedge i_clk);
        #1;
        alu_ack = 1'b1;
        cfg_write(5'd7, 32'h0BAD_F00D);
        issue(5'd7, 4'd6);
        drain();

        // reset mid-stream discards in-flight work and pending commits
        alu_ack = 1'b0;
        issue(5'd9, 4'd1);
        issue(5'd10, 4'd2);
        wb_dval = 1'b1;
        wait_cycles(1);
        wb_dval = 1'b0;
        i_rst = 1'b0;
        #1;
        check("mrst_alu_rdy", alu_rdy, 1'b0);
        check("mrst_commit", inst_commit_dval, 1'b0);
        check("mrst_o_inst", o_inst, 32'd0);
        check("mrst_o_pc", o_pc, 5'd0);
        check("mrst_o_bofs", o_bofs, 96'd0);
        sb.delete();
        wait_cycles(2);
        i_rst = 1'b1;
        c0 = commit_cnt;
        h0 = alu_hi_cnt;
        wait_cycles(6);
        check("mrst_no_commits", 96'(commit_cnt - c0), 96'd0);
        check("mrst_no_alu", 96'(alu_hi_cnt - h0), 96'd0);
        alu_ack = 1'b1;
        issue(5'd3, 4'd4);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
